// File: rtl/beat_pkg.sv
// Shared types and defaults for the beat step scheduler.
package beat_pkg;

  localparam int NUM_TRACKS = 4;
  localparam int NUM_STEPS  = 16;
  localparam int STEP_W     = $clog2(NUM_STEPS);
  localparam int TICK_W     = 26;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/tempo_tick.sv
// Tempo tick generator.
// Holds the step-length counter and the active period. A period loaded while
// running is parked until the current step ends, so a step never changes
// length once it has started.
module tempo_tick #(
  parameter int TICK_W         = beat_pkg::TICK_W,
  parameter int DEFAULT_PERIOD = 5000000
) (
  input  logic              clk,
  input  logic              poweron,
  input  logic              run,
  input  logic              clear,
  input  logic [TICK_W-1:0] tempo_period,
  input  logic              tempo_load,
  output logic              wrap
);
  import beat_pkg::*;

  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [TICK_W-1:0] period_q, period_d;
  logic [TICK_W-1:0] pend_val_q, pend_val_d;
  logic              pend_q, pend_d;
  logic [TICK_W-1:0] load_val;

  // Periods shorter than the minimum are raised to it.
  assign load_val = (tempo_period < TICK_W'(MIN_PERIOD)) ? TICK_W'(MIN_PERIOD) : tempo_period;

  // ">=" keeps the counter from running away if the period shrank while frozen.
  assign wrap = run && (cnt_q >= (period_q - 1'b1));

  // Step-length counter: restart on clear, count while running, wrap at period-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Period update: direct when not mid-step, otherwise parked until the next wrap.
  always_comb begin
    period_d   = period_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (tempo_load) begin
      if (run && !wrap) begin
        pend_d     = 1'b1;
        pend_val_d = load_val;
      end else begin
        period_d = load_val;
        pend_d   = 1'b0;
      end
    end else if ((wrap || clear) && pend_q) begin
      period_d = pend_val_q;
      pend_d   = 1'b0;
    end
  end

  // Tempo state registers.
  always_ff @(posedge clk or negedge poweron) begin
    if (!poweron) begin
      cnt_q      <= '0;
      period_q   <= TICK_W'(DEFAULT_PERIOD);
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

endmodule

// File: rtl/beat_step_scheduler.sv
// Beat step scheduler: transport FSM, step position, pattern store and
// registered trigger outputs for the sound/LED datapath.
module beat_step_scheduler #(
  parameter int NUM_TRACKS     = beat_pkg::NUM_TRACKS,
  parameter int NUM_STEPS      = beat_pkg::NUM_STEPS,
  parameter int TICK_W         = beat_pkg::TICK_W,
  parameter int DEFAULT_PERIOD = 5000000
) (
  input  logic                          clk,
  input  logic                          poweron,
  input  logic                          play,
  input  logic                          stop,
  input  logic [TICK_W-1:0]             tempo_period,
  input  logic                          tempo_load,
  input  logic                          pat_we,
  input  logic [$clog2(NUM_TRACKS)-1:0] pat_track,
  input  logic [$clog2(NUM_STEPS)-1:0]  pat_step,
  input  logic                          pat_bit,
  output logic [$clog2(NUM_STEPS)-1:0]  step,
  output logic [NUM_TRACKS-1:0]         trig,
  output logic                          playing,
  output logic                          beat_tick
);
  import beat_pkg::*;

  localparam int STEP_BITS = $clog2(NUM_STEPS);

  state_e                               state_q, state_d;
  logic [STEP_BITS-1:0]                 step_q, step_d;
  logic [NUM_TRACKS-1:0]                trig_q, trig_d;
  logic                                 beat_q, beat_d;
  logic [NUM_TRACKS-1:0][NUM_STEPS-1:0] pat_q, pat_d;
  logic [STEP_BITS-1:0]                 step_next;
  logic [NUM_TRACKS-1:0]                col_first, col_next;
  logic                                 run, clear, wrap;

  // NUM_STEPS is a power of two, so the natural overflow gives 15 -> 0.
  assign step_next = step_q + 1'b1;

  // The tick only advances in PLAY on cycles that are not a transport command.
  assign run   = (state_q == PLAY) && !play && !stop;
  assign clear = stop || ((state_q == IDLE) && play);

  tempo_tick #(
    .TICK_W         (TICK_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_tempo_tick (
    .clk          (clk),
    .poweron      (poweron),
    .run          (run),
    .clear        (clear),
    .tempo_period (tempo_period),
    .tempo_load   (tempo_load),
    .wrap         (wrap)
  );

  // Pattern columns read from the pre-write store, so a same-edge write is not seen.
  always_comb begin
    col_first = '0;
    col_next  = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      col_first[t] = pat_q[t][0];
      col_next[t]  = pat_q[t][step_next];
    end
  end

  // Transport FSM and step/trigger next-state; stop always beats play.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    trig_d  = '0;
    beat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stop && play) begin
          state_d = PLAY;
          step_d  = '0;
          trig_d  = col_first;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (play) begin
          state_d = PAUSE;
        end else if (wrap) begin
          step_d = step_next;
          beat_d = 1'b1;
          trig_d = col_next;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (play) begin
          state_d = PLAY;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Pattern store write port, usable in any transport state.
  always_comb begin
    pat_d = pat_q;
    if (pat_we) begin
      pat_d[pat_track][pat_step] = pat_bit;
    end
  end

  // Scheduler registers.
  always_ff @(posedge clk or negedge poweron) begin
    if (!poweron) begin
      state_q <= IDLE;
      step_q  <= '0;
      trig_q  <= '0;
      beat_q  <= 1'b0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      trig_q  <= trig_d;
      beat_q  <= beat_d;
      pat_q   <= pat_d;
    end
  end

  assign step      = step_q;
  assign trig      = trig_q;
  assign beat_tick = beat_q;
  assign playing   = (state_q == PLAY);

endmodule

// File: tb/tb_beat_step_scheduler.sv
// Testbench for beat_step_scheduler: a vector table, hand-written corner
// sequences and a randomized run against a cycle-level reference model.
module tb_beat_step_scheduler;

  localparam int NT = 4;
  localparam int NS = 16;
  localparam int TW = 26;

  logic          clk = 1'b0;
  logic          poweron;
  logic          play, stop, tempo_load, pat_we, pat_bit;
  logic [TW-1:0] tempo_period;
  logic [1:0]    pat_track;
  logic [3:0]    pat_step;
  logic [3:0]    step;
  logic [NT-1:0] trig;
  logic          playing, beat_tick;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic          play;
    logic          stop;
    logic          load;
    logic [TW-1:0] period;
    logic          we;
    logic [1:0]    trk;
    logic [3:0]    stp;
    logic          wbit;
  } in_t;

  typedef struct {
    in_t        i;
    int         exp_step;
    logic [3:0] exp_trig;
    logic       exp_play;
    logic       exp_beat;
  } vec_t;

  beat_step_scheduler dut (
    .clk          (clk),
    .poweron      (poweron),
    .play         (play),
    .stop         (stop),
    .tempo_period (tempo_period),
    .tempo_load   (tempo_load),
    .pat_we       (pat_we),
    .pat_track    (pat_track),
    .pat_step     (pat_step),
    .pat_bit      (pat_bit),
    .step         (step),
    .trig         (trig),
    .playing      (playing),
    .beat_tick    (beat_tick)
  );

  always #5 clk = ~clk;

  // Reference model: transport mode, elapsed cycles of the current step,
  // active period, parked period (-1 when none) and the pattern bits.
  int          m_mode;
  int          m_step;
  int          m_elapsed;
  int          m_period;
  int          m_pend;
  logic [3:0]  m_trig;
  logic        m_beat;
  logic [NS-1:0] m_pat [NT];

  function automatic void model_reset();
    m_mode    = 0;
    m_step    = 0;
    m_elapsed = 0;
    m_period  = 5000000;
    m_pend    = -1;
    m_trig    = '0;
    m_beat    = 1'b0;
    for (int t = 0; t < NT; t++) m_pat[t] = '0;
  endfunction

  function automatic logic [3:0] model_col(int s);
    logic [3:0] c;
    for (int t = 0; t < NT; t++) c[t] = m_pat[t][s];
    return c;
  endfunction

  function automatic void model_step(in_t v);
    int   req;
    logic running, adv, restart;
    req     = int'(v.period);
    if (req < 2) req = 2;
    running = (m_mode == 1) && !v.play && !v.stop;
    adv     = running && (m_elapsed + 1 >= m_period);
    restart = v.stop || ((m_mode == 0) && v.play);
    m_trig  = '0;
    m_beat  = 1'b0;
    if (v.load) begin
      if (running && !adv) m_pend = req;
      else begin
        m_period = req;
        m_pend   = -1;
      end
    end else if ((adv || restart) && m_pend >= 0) begin
      m_period = m_pend;
      m_pend   = -1;
    end
    if (restart) m_elapsed = 0;
    else if (running) m_elapsed = adv ? 0 : m_elapsed + 1;
    if (v.stop) begin
      m_mode = 0;
      m_step = 0;
    end else if (v.play) begin
      if (m_mode == 0) begin
        m_mode = 1;
        m_step = 0;
        m_trig = model_col(0);
      end else if (m_mode == 1) m_mode = 2;
      else m_mode = 1;
    end else if (adv) begin
      m_step = (m_step + 1) % NS;
      m_beat = 1'b1;
      m_trig = model_col(m_step);
    end
    if (v.we) m_pat[v.trk][v.stp] = v.wbit;
  endfunction

  function automatic in_t mk(logic pl, logic st, logic ld, int per, logic we, int trk, int stp, logic wb);
    in_t v;
    v.play   = pl;
    v.stop   = st;
    v.load   = ld;
    v.period = TW'(per);
    v.we     = we;
    v.trk    = 2'(trk);
    v.stp    = 4'(stp);
    v.wbit   = wb;
    return v;
  endfunction

  function automatic vec_t mkv(in_t i, int s, logic [3:0] t, logic p, logic b);
    vec_t e;
    e.i        = i;
    e.exp_step = s;
    e.exp_trig = t;
    e.exp_play = p;
    e.exp_beat = b;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare after it.
  task automatic applyStimulus(input in_t v);
    play         = v.play;
    stop         = v.stop;
    tempo_load   = v.load;
    tempo_period = v.period;
    pat_we       = v.we;
    pat_track    = v.trk;
    pat_step     = v.stp;
    pat_bit      = v.wbit;
    @(posedge clk);
    model_step(v);
    #1;
    checkOutput("model", {step, trig, playing, beat_tick},
                {4'(m_step), m_trig, (m_mode == 1), m_beat});
    play       = 1'b0;
    stop       = 1'b0;
    tempo_load = 1'b0;
    pat_we     = 1'b0;
  endtask

  in_t        IDLE_IN;
  in_t        PLAY_IN;
  in_t        STOP_IN;
  vec_t       tbl[$];
  int         offs[$];
  int         beats;
  int         errs;
  logic [3:0] trig_seen;
  logic       adv_k;
  int         s_k;
  in_t        r;

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    IDLE_IN = mk(0, 0, 0, 0, 0, 0, 0, 0);
    PLAY_IN = mk(1, 0, 0, 0, 0, 0, 0, 0);
    STOP_IN = mk(0, 1, 0, 0, 0, 0, 0, 0);
    play = 0; stop = 0; tempo_load = 0; tempo_period = '0;
    pat_we = 0; pat_track = '0; pat_step = '0; pat_bit = 0;
    poweron = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    poweron = 1'b1;
    #1;
    checkOutput("reset_outputs", {step, trig, playing, beat_tick}, 32'd0);

    // Vector table: pattern writes, tempo load, a play run and play+stop at step 5.
    tbl.push_back(mkv(mk(0, 0, 0, 0, 1, 0, 0, 1), 0, 4'b0000, 0, 0));
    tbl.push_back(mkv(mk(0, 0, 0, 0, 1, 0, 4, 1), 0, 4'b0000, 0, 0));
    tbl.push_back(mkv(mk(0, 0, 0, 0, 1, 0, 8, 1), 0, 4'b0000, 0, 0));
    tbl.push_back(mkv(mk(0, 0, 0, 0, 1, 0, 12, 1), 0, 4'b0000, 0, 0));
    tbl.push_back(mkv(mk(0, 0, 1, 4, 0, 0, 0, 0), 0, 4'b0000, 0, 0));
    tbl.push_back(mkv(PLAY_IN, 0, 4'b0001, 1, 0));
    for (int k = 1; k <= 20; k++) begin
      adv_k = (k % 4 == 0);
      s_k   = k / 4;
      tbl.push_back(mkv(IDLE_IN, s_k, (adv_k && (s_k % 4 == 0)) ? 4'b0001 : 4'b0000, 1, adv_k));
    end
    tbl.push_back(mkv(mk(1, 1, 0, 0, 0, 0, 0, 0), 0, 4'b0000, 0, 0));
    tbl.push_back(mkv(IDLE_IN, 0, 4'b0000, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].i);
      checkOutput($sformatf("vec%0d", i), {step, trig, playing, beat_tick},
                  {4'(tbl[i].exp_step), tbl[i].exp_trig, tbl[i].exp_play, tbl[i].exp_beat});
    end

    // Full pass at period 4: trig[0] at cycles 1,17,33,49; then the 15->0 wrap.
    offs.delete();
    beats = 0;
    errs  = 0;
    for (int k = 1; k <= 64; k++) begin
      applyStimulus((k == 1) ? PLAY_IN : IDLE_IN);
      if (trig[0]) offs.push_back(k);
      if (beat_tick) beats++;
      if (step !== 4'((k - 1) / 4)) errs++;
    end
    checkOutput("pass_trig_count", offs.size(), 4);
    if (offs.size() == 4) begin
      checkOutput("pass_trig_1", offs[0], 1);
      checkOutput("pass_trig_2", offs[1], 17);
      checkOutput("pass_trig_3", offs[2], 33);
      checkOutput("pass_trig_4", offs[3], 49);
    end
    checkOutput("pass_beats", beats, 15);
    checkOutput("pass_step_seq_errors", errs, 0);
    applyStimulus(IDLE_IN);
    checkOutput("pass_wrap", {step, trig, beat_tick}, {4'd0, 4'b0001, 1'b1});

    // Pause/resume: step holds while paused, advance 3 cycles after resume.
    applyStimulus(STOP_IN);
    applyStimulus(PLAY_IN);
    repeat (5) applyStimulus(IDLE_IN);
    checkOutput("pause_pre_step", step, 1);
    applyStimulus(PLAY_IN);
    checkOutput("pause_state", {playing, step}, {1'b0, 4'd1});
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(IDLE_IN);
      if (step !== 4'd1 || beat_tick !== 1'b0 || trig !== 4'd0) errs++;
    end
    checkOutput("pause_hold_errors", errs, 0);
    applyStimulus(PLAY_IN);
    checkOutput("resume_no_trig", {playing, step, trig, beat_tick}, {1'b1, 4'd1, 4'd0, 1'b0});
    applyStimulus(IDLE_IN);
    applyStimulus(IDLE_IN);
    checkOutput("resume_step_hold", step, 1);
    applyStimulus(IDLE_IN);
    checkOutput("resume_advance", {step, beat_tick}, {4'd2, 1'b1});

    // Tempo load mid-step: current step keeps 4 cycles, later ones take 8.
    applyStimulus(STOP_IN);
    applyStimulus(PLAY_IN);
    applyStimulus(mk(0, 0, 1, 8, 0, 0, 0, 0));
    offs.delete();
    for (int k = 2; k <= 30; k++) begin
      applyStimulus(IDLE_IN);
      if (beat_tick) offs.push_back(k);
    end
    checkOutput("tempo8_count", offs.size(), 4);
    if (offs.size() >= 3) begin
      checkOutput("tempo8_first", offs[0], 4);
      checkOutput("tempo8_second", offs[1], 12);
      checkOutput("tempo8_third", offs[2], 20);
    end

    // Clamp: loads of 0 and 1 both give 2-cycle steps.
    applyStimulus(STOP_IN);
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0));
    applyStimulus(PLAY_IN);
    offs.delete();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(IDLE_IN);
      if (beat_tick) offs.push_back(k);
    end
    checkOutput("clamp0_count", offs.size(), 4);
    if (offs.size() >= 2) begin
      checkOutput("clamp0_first", offs[0], 2);
      checkOutput("clamp0_second", offs[1], 4);
    end
    applyStimulus(STOP_IN);
    applyStimulus(mk(0, 0, 1, 1, 0, 0, 0, 0));
    applyStimulus(PLAY_IN);
    offs.delete();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(IDLE_IN);
      if (beat_tick) offs.push_back(k);
    end
    checkOutput("clamp1_count", offs.size(), 2);
    if (offs.size() >= 1) checkOutput("clamp1_first", offs[0], 2);

    // Write to track 2 step 3 on the edge that enters step 3.
    applyStimulus(STOP_IN);
    applyStimulus(mk(0, 0, 1, 4, 0, 0, 0, 0));
    applyStimulus(PLAY_IN);
    repeat (11) applyStimulus(IDLE_IN);
    applyStimulus(mk(0, 0, 0, 0, 1, 2, 3, 1));
    checkOutput("same_edge_old_value", {step, trig, beat_tick}, {4'd3, 4'b0000, 1'b1});
    repeat (64) applyStimulus(IDLE_IN);
    checkOutput("same_edge_next_pass", {step, trig}, {4'd3, 4'b0100});

    // Asynchronous reset between edges, right after a triggering advance.
    repeat (4) applyStimulus(IDLE_IN);
    checkOutput("pre_reset_trig", {step, trig, beat_tick}, {4'd4, 4'b0001, 1'b1});
    #1;
    poweron = 1'b0;
    model_reset();
    #1;
    checkOutput("async_reset_outputs", {step, trig, playing, beat_tick}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    poweron = 1'b1;
    applyStimulus(PLAY_IN);
    beats = 0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(IDLE_IN);
      if (beat_tick) beats++;
    end
    checkOutput("default_period_no_beat", beats, 0);
    checkOutput("default_period_playing", {playing, step}, {1'b1, 4'd0});
    applyStimulus(STOP_IN);
    applyStimulus(mk(0, 0, 1, 2, 0, 0, 0, 0));
    applyStimulus(PLAY_IN);
    beats     = 0;
    trig_seen = '0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(IDLE_IN);
      if (beat_tick) beats++;
      trig_seen = trig_seen | trig;
    end
    checkOutput("cleared_pattern_beats", beats, 20);
    checkOutput("cleared_pattern_no_trig", trig_seen, 0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      r.play   = ($urandom_range(0, 99) < 3);
      r.stop   = ($urandom_range(0, 99) < 1);
      r.load   = ($urandom_range(0, 99) < 3);
      r.period = TW'($urandom_range(0, 7));
      r.we     = ($urandom_range(0, 99) < 20);
      r.trk    = 2'($urandom_range(0, 3));
      r.stp    = 4'($urandom_range(0, 15));
      r.wbit   = 1'($urandom_range(0, 1));
      applyStimulus(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/beat_step_scheduler.md
# beat_step_scheduler

Sequencing controller for the beat sequencer. It owns the transport (idle/play/pause), the programmable tempo tick, the 16-step position, and the per-track pattern store. On every step boundary it emits one-cycle trigger pulses to the sound/LED datapath. It replaces the free-running step counter with a controllable, tempo-programmable scheduler.

## Interface

Parameters:
- NUM_TRACKS, 4, number of instrument tracks (trigger outputs)
- NUM_STEPS, 16, steps per pattern (power of two)
- TICK_W, 26, tempo counter width
- DEFAULT_PERIOD, 5000000, clk cycles per step after reset

Ports:
- clk  in  1  system clock
- poweron  in  1  asynchronous, active-low reset
- play  in  1  one-cycle pulse: start, pause or resume
- stop  in  1  one-cycle pulse: return to idle
- tempo_period  in  TICK_W  requested cycles per step
- tempo_load  in  1  pulse: capture tempo_period
- pat_we  in  1  pattern write enable
- pat_track  in  $clog2(NUM_TRACKS)  track to write
- pat_step  in  $clog2(NUM_STEPS)  step to write
- pat_bit  in  1  value to write
- step  out  $clog2(NUM_STEPS)  current step
- trig  out  NUM_TRACKS  one-cycle trigger pulses
- playing  out  1  high in PLAY
- beat_tick  out  1  one-cycle pulse on each step advance

## Operation

- Reset (poweron low, asynchronous):
  - state=IDLE, step=0, trig=0, playing=0, beat_tick=0
  - tick counter=0, period=DEFAULT_PERIOD, pending-period flag clear
  - all pattern bits 0
- FSM states: IDLE, PLAY, PAUSE.
  - IDLE + play → PLAY. step=0, tick counter=0, trig=pattern[*][0].
  - PLAY + play → PAUSE. Tick counter and step freeze.
  - PAUSE + play → PLAY. The counter resumes from its frozen value; no trigger fires on resume.
  - Any state + stop → IDLE. step=0, tick counter=0.
  - If stop and play are high together, stop wins.
- Tempo tick (PLAY only):
  - The counter runs 0..period-1.
  - At period-1 it wraps to 0, step increments modulo NUM_STEPS (15→0), beat_tick=1, and trig=pattern[*][new step].
- Tempo load:
  - Any tempo_period value below 2 is clamped to 2.
  - In IDLE or PAUSE the new period takes effect on the next cycle.
  - In PLAY it is held pending and applied at the next wrap, so the current step keeps its old length.
  - A second load before that wrap overwrites the pending value.
- Pattern store: a NUM_TRACKS×NUM_STEPS flop array, writable in any state.
  - A write takes effect on the edge after pat_we.
  - If a write targets the step being triggered on the same edge, the trigger uses the old value.
- trig and beat_tick are zero in every cycle other than the ones specified above.

## Timing

- All outputs are registered.
- Play pulse sampled at edge N: playing=1, step=0 and trig are valid after edge N. Latency is 1 cycle.
- Step k begins at edge E. The next advance occurs at edge E+period.
- trig and beat_tick are high for exactly one cycle, coincident with the step update.
- stop sampled at edge N: playing=0 and step=0 after edge N. Any trig that would have fired at N is suppressed.
- Reset asserted mid-step clears all outputs immediately, with no clock required.
- Pause does not change period accounting: the cycles spent in PLAY before and after a pause sum to period.

## Structure

- Shared package beat_pkg:
  - state enum (IDLE, PLAY, PAUSE)
  - NUM_STEPS and NUM_TRACKS defaults
  - STEP_W and TICK_W localparams
  - MIN_PERIOD=2
- One sub-module, tempo_tick: counter, period register, pending-load logic and clamp.
  - Inputs: run, clear, tempo_period, tempo_load.
  - Output: a one-cycle wrap pulse.
- The FSM, step register and pattern array live in beat_step_scheduler.

## Test plan

- Reset, then write pattern track0 = steps {0,4,8,12}, load period 4, pulse play. Required: trig[0] pulses at cycles 1, 17, 33, 49 after play; step counts 0→15→0; beat_tick every 4 cycles.
- Play for 6 cycles at period 4 (step=1, counter=1), pulse play, wait 20 cycles, pulse play again. Required: step holds at 1 while paused; the advance to 2 occurs 3 cycles after resume.
- Load period 8 mid-step while playing at period 4. Required: the current step still lasts 4 cycles; later steps last 8. Load 0 or 1: steps last 2 cycles.
- Assert play and stop together while playing at step 5. Required: IDLE, step=0, playing=0, no trig.
- Write pat_bit=1 to track 2 on the same edge that step 3 is entered. Required: no trig[2] at step 3; trig[2] fires at step 3 on the next pass.
- Assert poweron low asynchronously between clock edges mid-pattern. Required: all outputs 0 immediately; the pattern array is cleared; period reverts to 5000000.
